// File: rtl/jtframe_osd_keyenc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_osd_keyenc_pkg
// Brief   : Shared key/command codes, output bytes, FSM states and the
//           joystick direction priority encoder for the OSD key encoder.
// Revision: 1.0 - initial release
// ============================================================================
package jtframe_osd_keyenc_pkg;

  // Key codes are active-low one-cold patterns in the low five bits
  localparam logic [4:0] C_KEY_R    = 5'd23;
  localparam logic [4:0] C_KEY_L    = 5'd27;
  localparam logic [4:0] C_KEY_D    = 5'd29;
  localparam logic [4:0] C_KEY_U    = 5'd30;
  localparam logic [4:0] C_KEY_RET  = 5'd15;
  localparam logic [4:0] C_KEY_NONE = 5'd31;

  localparam logic [2:0] C_CMD_NOP  = 3'b111;
  localparam logic [2:0] C_CMD_OSD  = 3'b011;

  localparam logic [7:0] C_BYTE_BOOT = 8'hff;
  localparam logic [7:0] C_BYTE_GATE = 8'h3f;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_GATE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Bits are R,L,D,U,fire; the lowest set bit wins
  function automatic logic [4:0] key_code(input logic [4:0] dirs);
    if (dirs[0])      return C_KEY_R;
    else if (dirs[1]) return C_KEY_L;
    else if (dirs[2]) return C_KEY_D;
    else if (dirs[3]) return C_KEY_U;
    else if (dirs[4]) return C_KEY_RET;
    else              return C_KEY_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_osd_keyenc_if.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_osd_keyenc_if
// Brief   : Joystick/download inputs and OSD byte outputs of the key encoder.
// Revision: 1.0 - initial release
// ============================================================================
interface jtframe_osd_keyenc_if #(
  parameter int NJOY = 2,
  parameter int JW   = 12
);
  logic [NJOY*JW-1:0] joy;
  logic               dwn_done;
  logic [7:0]         osd_byte;
  logic               osd_fire;
  logic               key_evt;

  modport master (output joy, dwn_done, input osd_byte, osd_fire, key_evt);
  modport slave  (input joy, dwn_done, output osd_byte, osd_fire, key_evt);
endinterface
`default_nettype wire

// File: rtl/jtframe_osd_keyenc_repeat.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_osd_keyenc_repeat
// Brief   : Direction priority encoder with per-key autorepeat timing.
//           key_nxt is the next value of the key field, emit marks an
//           emission (first press or repeat) on this clk.
// Revision: 1.0 - initial release
// ============================================================================
module jtframe_osd_keyenc_repeat
  import jtframe_osd_keyenc_pkg::*;
#(
  parameter int REP_DELAY = 30,
  parameter int REP_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       cen,
  input  logic [4:0] dirs,
  output logic [4:0] key_nxt,
  output logic       emit
);
  localparam int TMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int TW   = $clog2(TMAX + 1) + 1;
  localparam logic [TW-1:0] C_DELAY = TW'(REP_DELAY);
  localparam logic [TW-1:0] C_RATE  = TW'(REP_RATE);

  logic [4:0]    win_q, win_d, key_q, key_d, w_win;
  logic [TW-1:0] tick_q, tick_d, w_tick_inc;
  logic          rep_q, rep_d;

  // Winner tracking: new winner emits at once, then delay, then fixed rate.
  // The tick counter reloads on every emission so it never exceeds its target.
  always_comb begin
    w_win      = key_code(dirs);
    w_tick_inc = tick_q + 1'b1;
    win_d      = win_q;
    key_d      = key_q;
    tick_d     = tick_q;
    rep_d      = rep_q;
    emit       = 1'b0;
    if (!run) begin
      win_d  = C_KEY_NONE;
      key_d  = C_KEY_NONE;
      tick_d = '0;
      rep_d  = 1'b0;
    end else if (cen) begin
      if (w_win == C_KEY_NONE) begin
        win_d  = C_KEY_NONE;
        key_d  = C_KEY_NONE;
        tick_d = '0;
        rep_d  = 1'b0;
      end else if (w_win != win_q) begin
        win_d  = w_win;
        key_d  = w_win;
        tick_d = '0;
        rep_d  = 1'b0;
        emit   = 1'b1;
      end else if (w_tick_inc >= (rep_q ? C_RATE : C_DELAY)) begin
        key_d  = w_win;
        tick_d = '0;
        rep_d  = 1'b1;
        emit   = 1'b1;
      end else begin
        key_d  = C_KEY_NONE;
        tick_d = w_tick_inc;
      end
    end
  end

  // Timer and key state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= C_KEY_NONE;
      key_q  <= C_KEY_NONE;
      tick_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      win_q  <= win_d;
      key_q  <= key_d;
      tick_q <= tick_d;
      rep_q  <= rep_d;
    end
  end

  assign key_nxt = key_d;

endmodule
`default_nettype wire

// File: rtl/jtframe_osd_keyenc.sv
`default_nettype none
// ============================================================================
// Module  : jtframe_osd_keyenc
// Brief   : Joystick to OSD command byte encoder: boot hold-off, download
//           gate, timed OSD hotkey with release re-arm, key autorepeat.
// Revision: 1.0 - initial release
// ============================================================================
module jtframe_osd_keyenc
  import jtframe_osd_keyenc_pkg::*;
#(
  parameter int              NJOY       = 2,
  parameter int              JW         = 12,
  parameter int              BOOT_CNT   = 65535,
  parameter logic [JW-1:0]   OSD_MASK   = 'h440,
  parameter int              HOLD_LINES = 4,
  parameter int              CMD_LINES  = 8,
  parameter int              REP_DELAY  = 30,
  parameter int              REP_RATE   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  jtframe_osd_keyenc_if.slave   bus
);
  localparam int BW = (BOOT_CNT > 0) ? $clog2(BOOT_CNT + 1) : 1;
  localparam int HW = $clog2(HOLD_LINES + 2);
  localparam int CW = (CMD_LINES > 0) ? $clog2(CMD_LINES + 1) : 1;
  localparam logic [BW-1:0] C_BOOT = BW'(BOOT_CNT);
  localparam logic [HW-1:0] C_HOLD = HW'(HOLD_LINES);
  localparam logic [HW-1:0] C_HMAX = HW'(HOLD_LINES + 1);
  localparam logic [CW-1:0] C_CMD  = CW'(CMD_LINES);

  state_e        state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          armed_q, armed_d;
  logic [7:0]    osd_byte_q, osd_byte_d;
  logic          osd_fire_q, osd_fire_d;
  logic          key_evt_q, key_evt_d;
  logic [JW-1:0] w_mix;
  logic          w_combo, w_run, w_emit;
  logic [4:0]    w_key;

  // All joystick ports are merged into one word
  always_comb begin
    w_mix = '0;
    for (int i = 0; i < NJOY; i++) w_mix = w_mix | bus.joy[i*JW +: JW];
  end

  assign w_run   = (state_q == ST_RUN);
  assign w_combo = (OSD_MASK != '0) && ((w_mix & OSD_MASK) == OSD_MASK);

  jtframe_osd_keyenc_repeat #(
    .REP_DELAY (REP_DELAY),
    .REP_RATE  (REP_RATE)
  ) u_repeat (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_run),
    .cen     (cen),
    .dirs    (w_mix[4:0]),
    .key_nxt (w_key),
    .emit    (w_emit)
  );

  // BOOT/GATE/RUN sequencing; the boot counter runs on clk, not on cen
  always_comb begin
    state_d = state_q;
    boot_d  = boot_q;
    case (state_q)
      ST_BOOT: begin
        boot_d = (boot_q == '0) ? '0 : boot_q - 1'b1;
        if (boot_d == '0) state_d = ST_GATE;
      end
      ST_GATE: if (bus.dwn_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Hotkey: count held ticks, fire once at HOLD_LINES, re-arm on release
  always_comb begin
    hold_d     = hold_q;
    cmd_d      = cmd_q;
    armed_d    = armed_q;
    osd_fire_d = 1'b0;
    if (!w_run) begin
      hold_d  = '0;
      cmd_d   = '0;
      armed_d = 1'b1;
    end else if (cen) begin
      if (cmd_q != '0) cmd_d = cmd_q - 1'b1;
      if (w_combo) begin
        if (hold_q != C_HMAX) hold_d = hold_q + 1'b1;
        if (armed_q && (hold_q == C_HOLD)) begin
          cmd_d      = C_CMD;
          armed_d    = 1'b0;
          osd_fire_d = 1'b1;
        end
      end else begin
        hold_d  = '0;
        armed_d = 1'b1;
      end
    end
  end

  // Output byte follows the next state so it is valid the clk it changes
  always_comb begin
    key_evt_d = w_emit;
    case (state_d)
      ST_BOOT: osd_byte_d = C_BYTE_BOOT;
      ST_GATE: osd_byte_d = C_BYTE_GATE;
      default: osd_byte_d = {(cmd_d != '0) ? C_CMD_OSD : C_CMD_NOP, w_key};
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_q     <= C_BOOT;
      hold_q     <= '0;
      cmd_q      <= '0;
      armed_q    <= 1'b1;
      osd_byte_q <= C_BYTE_BOOT;
      osd_fire_q <= 1'b0;
      key_evt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_q     <= boot_d;
      hold_q     <= hold_d;
      cmd_q      <= cmd_d;
      armed_q    <= armed_d;
      osd_byte_q <= osd_byte_d;
      osd_fire_q <= osd_fire_d;
      key_evt_q  <= key_evt_d;
    end
  end

  assign bus.osd_byte = osd_byte_q;
  assign bus.osd_fire = osd_fire_q;
  assign bus.key_evt  = key_evt_q;

endmodule
`default_nettype wire
